// File: rtl/lcd_bus_scheduler_pkg.sv
// Shared types and constants for the LCD bus scheduler.
// Latency: none (package). Backpressure: n/a.
// Holds the state encoding, the power-up command ROM and the long-settle command classifier.
package lcd_pkg;

    typedef enum logic [2:0] {
        ST_PWRUP,
        ST_INIT_LOAD,
        ST_SETUP,
        ST_EN_HI,
        ST_HOLD,
        ST_WAIT,
        ST_IDLE
    } lcd_state_e;

    localparam int INIT_LEN = 4;
    // Element 0 is issued first: function set, display on, entry mode, clear.
    localparam logic [INIT_LEN-1:0][7:0] INIT_ROM = {8'h01, 8'h06, 8'h0E, 8'h38};

    localparam logic [7:0] CMD_CLEAR = 8'h01;
    localparam logic [7:0] CMD_HOME  = 8'h02;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Home ignores bit 0, so 0x02 and 0x03 both need the long settle.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && ((data == CMD_CLEAR) || (data[7:1] == CMD_HOME[7:1]));
    endfunction

endpackage

// File: rtl/lcd_rr_arbiter.sv
// Two-way round-robin arbiter with a one-hot (or empty) grant.
// Latency: grant combinational; pointer updates on the edge after accept.
// Backpressure: pointer only moves when the owner signals an accept.
module lcd_rr_arbiter (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] valid,
    input  logic       accept,
    output logic [1:0] grant,
    output logic       rr_ptr
);

    logic rr_q, rr_d;

    // rr_q=1 means requester 1 wins a tie.
    always_comb begin
        grant = valid;
        if (valid == 2'b11) begin
            grant = rr_q ? 2'b10 : 2'b01;
        end
        rr_d = accept ? grant[0] : rr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end

    assign rr_ptr = rr_q;

endmodule

// File: rtl/lcd_bus_scheduler.sv
// HD44780 8-bit bus owner: power-up init, then round-robin byte scheduling.
// Latency: accept at t -> en high t+1+SETUP .. +EN_HIGH, next accept after hold and settle.
// Backpressure: readies low outside IDLE or before init completes; requests are held.
module lcd_bus_scheduler
    import lcd_pkg::*;
#(
    parameter int PWRUP_CYC     = 16,
    parameter int SETUP_CYC     = 2,
    parameter int EN_HIGH_CYC   = 4,
    parameter int HOLD_CYC      = 2,
    parameter int CMD_WAIT_CYC  = 8,
    parameter int LONG_WAIT_CYC = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0_valid,
    input  logic       req0_rs,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic       req1_rs,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_en,
    output logic [7:0] lcd_dout,
    output logic       init_done,
    output logic       busy
);

    localparam int MAX_CYC = max2(max2(max2(PWRUP_CYC, SETUP_CYC), max2(EN_HIGH_CYC, HOLD_CYC)),
                                  max2(CMD_WAIT_CYC, LONG_WAIT_CYC));
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
    localparam int IDX_W   = $clog2(INIT_LEN);

    lcd_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             rs_q, rs_d;
    logic [7:0]       dat_q, dat_d;
    logic             init_done_q, init_done_d;
    logic [1:0]       grant, ready;
    logic             accept, rr_ptr;
    logic [CNT_W-1:0] wait_last;

    assign ready  = (state_q == ST_IDLE && init_done_q) ? grant : 2'b00;
    assign accept = |(ready & {req1_valid, req0_valid});

    lcd_rr_arbiter u_arb (
        .clk    (clk),
        .rst    (rst),
        .valid  ({req1_valid, req0_valid}),
        .accept (accept),
        .grant  (grant),
        .rr_ptr (rr_ptr)
    );

    // cnt_q counts cycles spent in the current timed state, from 0.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q + CNT_W'(1);
        idx_d       = idx_q;
        rs_d        = rs_q;
        dat_d       = dat_q;
        init_done_d = init_done_q;
        wait_last   = is_long_cmd(rs_q, dat_q) ? CNT_W'(LONG_WAIT_CYC - 1) : CNT_W'(CMD_WAIT_CYC - 1);
        case (state_q)
            ST_PWRUP: if (cnt_q == CNT_W'(PWRUP_CYC - 1)) begin
                state_d = ST_INIT_LOAD;
                cnt_d   = '0;
            end
            ST_INIT_LOAD: begin
                rs_d    = 1'b0;
                dat_d   = INIT_ROM[idx_q];
                state_d = ST_SETUP;
                cnt_d   = '0;
            end
            ST_SETUP: if (cnt_q == CNT_W'(SETUP_CYC - 1)) begin
                state_d = ST_EN_HI;
                cnt_d   = '0;
            end
            ST_EN_HI: if (cnt_q == CNT_W'(EN_HIGH_CYC - 1)) begin
                state_d = ST_HOLD;
                cnt_d   = '0;
            end
            ST_HOLD: if (cnt_q == CNT_W'(HOLD_CYC - 1)) begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end
            ST_WAIT: if (cnt_q == wait_last) begin
                cnt_d   = '0;
                state_d = ST_IDLE;
                if (!init_done_q) begin
                    if (idx_q == IDX_W'(INIT_LEN - 1)) begin
                        init_done_d = 1'b1;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_INIT_LOAD;
                    end
                end
            end
            default: begin
                cnt_d = '0;
                if (accept) begin
                    rs_d    = ready[1] ? req1_rs : req0_rs;
                    dat_d   = ready[1] ? req1_data : req0_data;
                    state_d = ST_SETUP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_PWRUP;
            cnt_q       <= '0;
            idx_q       <= '0;
            rs_q        <= 1'b0;
            dat_q       <= 8'h00;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            rs_q        <= rs_d;
            dat_q       <= dat_d;
            init_done_q <= init_done_d;
        end
    end

    assign req0_ready = ready[0];
    assign req1_ready = ready[1];
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_en     = (state_q == ST_EN_HI);
    assign lcd_dout   = dat_q;
    assign init_done  = init_done_q;
    assign busy       = (state_q != ST_IDLE);

    param_nonzero: assert property (@(posedge clk)
        (PWRUP_CYC >= 1) && (SETUP_CYC >= 1) && (EN_HIGH_CYC >= 1) &&
        (HOLD_CYC >= 1) && (CMD_WAIT_CYC >= 1) && (LONG_WAIT_CYC >= 1))
        else $error("lcd_bus_scheduler: timing parameters must be >= 1");

    // After serving requester 0 the tie-break must favour requester 1, and vice versa.
    rr_follows_accept: assert property (@(posedge clk) disable iff (rst)
        accept |=> (rr_ptr == $past(ready[0])));

endmodule

// File: tb/tb_lcd_bus_scheduler.sv
module tb_lcd_bus_scheduler;

    localparam int PWRUP = 16;
    localparam int S     = 2;
    localparam int E     = 4;
    localparam int H     = 2;
    localparam int CMDW  = 8;
    localparam int LONGW = 32;
    localparam logic [7:0] ROM [4] = '{8'h38, 8'h0E, 8'h06, 8'h01};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0_valid = 1'b0, req0_rs = 1'b0, req1_valid = 1'b0, req1_rs = 1'b0;
    logic [7:0] req0_data = 8'h00, req1_data = 8'h00;
    logic       req0_ready, req1_ready, lcd_rs, lcd_rw, lcd_en, init_done, busy;
    logic [7:0] lcd_dout;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    int last_served = 1;

    lcd_bus_scheduler #(
        .PWRUP_CYC(PWRUP), .SETUP_CYC(S), .EN_HIGH_CYC(E),
        .HOLD_CYC(H), .CMD_WAIT_CYC(CMDW), .LONG_WAIT_CYC(LONGW)
    ) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_rs(req0_rs), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_rs(req1_rs), .req1_data(req1_data), .req1_ready(req1_ready),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_dout(lcd_dout),
        .init_done(init_done), .busy(busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference timing: settle length and accept-to-idle span of one byte.
    function automatic int wait_of(input logic rs, input logic [7:0] d);
        return (!rs && d >= 8'h01 && d <= 8'h03) ? LONGW : CMDW;
    endfunction

    function automatic int span(input logic rs, input logic [7:0] d);
        return 1 + S + E + H + wait_of(rs, d);
    endfunction

    function automatic int init_rise(input int k);
        int t = PWRUP;
        for (int j = 0; j < k; j++) t += span(1'b0, ROM[j]);
        return t + 1 + S;
    endfunction

    function automatic int init_total();
        int t = PWRUP;
        for (int j = 0; j < 4; j++) t += span(1'b0, ROM[j]);
        return t;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b1;
        repeat (n) step();
        rst = 1'b0;
        last_served = 1;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 100 && busy !== 1'b0; i++) step();
        tests++;
        if (busy !== 1'b0) begin
            fails++;
            $display("FAIL wait_idle: busy=%b, want 0 within 100 cycles", busy);
        end
    endtask

    // Follows the init sequence from the cycle after reset release; optionally a held req0.
    task automatic run_init(input bit pend, input logic prs, input logic [7:0] d);
        int n_rise = 0, rise_rel = 0, done_rel = -1;
        logic prev_en = 1'b0;
        for (int rel = 1; rel <= 400; rel++) begin
            step();
            if (lcd_en === 1'b1 && prev_en === 1'b0) begin
                tests++;
                if (n_rise >= 4 || rel != init_rise(n_rise) || lcd_dout !== ROM[n_rise % 4] || lcd_rs !== 1'b0) begin
                    fails++;
                    $display("FAIL init_pulse #%0d: at %0d dout=%h rs=%b, want at %0d dout=%h rs=0",
                             n_rise, rel, lcd_dout, lcd_rs, init_rise(n_rise % 4), ROM[n_rise % 4]);
                end
                rise_rel = rel;
                n_rise++;
            end
            if (lcd_en === 1'b0 && prev_en === 1'b1) begin
                tests++;
                if (rel - rise_rel != E) begin
                    fails++;
                    $display("FAIL init_en_width: got %0d, want %0d", rel - rise_rel, E);
                end
            end
            prev_en = lcd_en;
            if (init_done === 1'b1) begin
                done_rel = rel;
                break;
            end
            tests++;
            if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL init_blocked at %0d: rdy0=%b rdy1=%b busy=%b, want 0 0 1",
                         rel, req0_ready, req1_ready, busy);
            end
        end
        tests++;
        if (done_rel != init_total() || n_rise != 4) begin
            fails++;
            $display("FAIL init_done_time: rose at %0d after %0d pulses, want %0d after 4",
                     done_rel, n_rise, init_total());
        end
        tests++;
        if (busy !== 1'b0 || req0_ready !== pend) begin
            fails++;
            $display("FAIL init_first_idle: busy=%b rdy0=%b, want 0 %b", busy, req0_ready, pend);
        end
        if (pend) begin
            last_served = 0;
            step();
            req0_valid = 1'b0;
            #1;
            tests++;
            if (lcd_dout !== d || lcd_rs !== prs) begin
                fails++;
                $display("FAIL held_byte: dout=%h rs=%b, want %h %b", lcd_dout, lcd_rs, d, prs);
            end
            wait_idle();
        end
    endtask

    // One byte from one requester with cycle-by-cycle checks of en, busy and bus values.
    task automatic xfer(input int which, input logic rs, input logic [7:0] d);
        int  lat = span(rs, d);
        logic exp_en, exp_busy;
        step();
        if (which == 0) begin req0_valid = 1'b1; req0_rs = rs; req0_data = d; end
        else            begin req1_valid = 1'b1; req1_rs = rs; req1_data = d; end
        #1;
        tests++;
        if ((which == 0 ? req0_ready : req1_ready) !== 1'b1) begin
            fails++;
            $display("FAIL xfer_ready req%0d: got 0, want 1", which);
        end
        last_served = which;
        for (int k = 1; k <= lat; k++) begin
            step();
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            #1;
            exp_en   = (k >= 1 + S) && (k < 1 + S + E);
            exp_busy = (k < lat);
            tests++;
            if (lcd_en !== exp_en || busy !== exp_busy || lcd_rs !== rs || lcd_dout !== d || lcd_rw !== 1'b0) begin
                fails++;
                $display("FAIL xfer req%0d %h k=%0d: en=%b busy=%b rs=%b dout=%h rw=%b, want %b %b %b %h 0",
                         which, d, k, lcd_en, busy, lcd_rs, lcd_dout, lcd_rw, exp_en, exp_busy, rs, d);
            end
        end
    endtask

    // Traffic from both requesters against a model of the grant rule and byte timing.
    task automatic run_traffic(input int n, input bit fixed);
        bit         v [2] = '{1'b0, 1'b0};
        logic       r [2];
        logic [7:0] dd [2];
        int         idle_at = cyc, acc = 0, k;
        logic       ers = 1'b0;
        logic [7:0] ed = 8'h00;
        bit         have = 1'b0;
        logic [1:0] g;
        for (int it = 0; it < 4000 && acc < n; it++) begin
            step();
            for (int i = 0; i < 2; i++) begin
                if (!v[i] && (fixed || $urandom_range(0, 2) == 0)) begin
                    v[i] = 1'b1;
                    if (fixed) begin
                        r[i]  = 1'b1;
                        dd[i] = (i == 0) ? 8'h41 : 8'h42;
                    end else begin
                        r[i]  = 1'($urandom_range(0, 1));
                        dd[i] = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 4)) : 8'($urandom);
                    end
                end
            end
            req0_valid = v[0]; req0_rs = r[0]; req0_data = dd[0];
            req1_valid = v[1]; req1_rs = r[1]; req1_data = dd[1];
            #1;
            if (cyc < idle_at)      g = 2'b00;
            else if (v[0] && v[1])  g = (last_served == 1) ? 2'b01 : 2'b10;
            else                    g = {v[1], v[0]};
            tests++;
            if ({req1_ready, req0_ready} !== g) begin
                fails++;
                $display("FAIL traffic_grant cyc=%0d: ready=%b%b, want %b", cyc, req1_ready, req0_ready, g);
            end
            if (have) begin
                tests++;
                if (lcd_rs !== ers || lcd_dout !== ed) begin
                    fails++;
                    $display("FAIL traffic_bus cyc=%0d: rs=%b dout=%h, want %b %h", cyc, lcd_rs, lcd_dout, ers, ed);
                end
            end
            if (g != 2'b00) begin
                k = g[1] ? 1 : 0;
                ers = r[k];
                ed = dd[k];
                have = 1'b1;
                idle_at = cyc + span(ers, ed);
                last_served = k;
                v[k] = 1'b0;
                acc++;
            end
        end
        step();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        wait_idle();
        tests++;
        if (acc != n) begin
            fails++;
            $display("FAIL traffic_count: %0d accepts, want %0d", acc, n);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        repeat (3) step();
        tests++; if (lcd_en !== 1'b0)     begin fails++; $display("FAIL reset_en: %b want 0", lcd_en); end
        tests++; if (lcd_rs !== 1'b0)     begin fails++; $display("FAIL reset_rs: %b want 0", lcd_rs); end
        tests++; if (lcd_dout !== 8'h00)  begin fails++; $display("FAIL reset_dout: %h want 00", lcd_dout); end
        tests++; if (lcd_rw !== 1'b0)     begin fails++; $display("FAIL reset_rw: %b want 0", lcd_rw); end
        tests++; if (init_done !== 1'b0)  begin fails++; $display("FAIL reset_init_done: %b want 0", init_done); end
        tests++; if (busy !== 1'b1)       begin fails++; $display("FAIL reset_busy: %b want 1", busy); end
        tests++; if ({req1_ready, req0_ready} !== 2'b00) begin
            fails++; $display("FAIL reset_ready: %b%b want 00", req1_ready, req0_ready);
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_init();
        do_reset(2);
        run_init(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_single();
        xfer(0, 1'b1, 8'h76);
    endtask

    task automatic test_round_robin();
        run_traffic(8, 1'b1);
    endtask

    task automatic test_long_cmd();
        xfer(1, 1'b0, 8'h01);
        xfer(1, 1'b1, 8'h01);
        xfer(0, 1'b0, 8'h02);
        xfer(1, 1'b0, 8'h03);
        xfer(0, 1'b0, 8'h04);
    endtask

    task automatic test_random();
        run_traffic(40, 1'b0);
    endtask

    task automatic test_backpressure();
        logic [7:0] d = 8'($urandom);
        req0_valid = 1'b1;
        req0_rs    = 1'b1;
        req0_data  = d;
        do_reset(2);
        run_init(1'b1, 1'b1, d);
    endtask

    task automatic test_midreset();
        logic [7:0] d2 = 8'($urandom);
        step();
        req0_valid = 1'b1; req0_rs = 1'b1; req0_data = 8'h5A;
        #1;
        tests++;
        if (req0_ready !== 1'b1) begin fails++; $display("FAIL midrst_accept: rdy0=%b want 1", req0_ready); end
        step();
        req0_data = d2;
        for (int i = 0; i < 20 && lcd_en !== 1'b1; i++) step();
        tests++;
        if (lcd_en !== 1'b1) begin fails++; $display("FAIL midrst_en_seen: en=%b want 1", lcd_en); end
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        last_served = 1;
        #1;
        tests++;
        if (lcd_en !== 1'b0 || init_done !== 1'b0 || req0_ready !== 1'b0) begin
            fails++;
            $display("FAIL midrst_state: en=%b init_done=%b rdy0=%b, want 0 0 0", lcd_en, init_done, req0_ready);
        end
        run_init(1'b1, 1'b1, d2);
    endtask

    initial begin
        test_reset();
        test_init();
        test_single();
        test_round_robin();
        test_long_cmd();
        test_random();
        test_backpressure();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
